// File: rtl/apb_arb_pkg.sv
// Shared types for the two-requester APB arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package apb_arb_pkg;

    localparam int NB_REQ = 2;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2
    } arb_state_t;

    // Round-robin pick: on a tie the requester that did not own the last transfer wins.
    function automatic logic pick_winner(input logic req0, input logic req1, input logic last_grant);
        logic win;
        win = (req0 && req1) ? ~last_grant : req1;
        return win;
    endfunction

endpackage

// File: rtl/apb_arb_timeout.sv
// ACCESS-phase watchdog: clears while in SETUP, counts ACCESS cycles, flags the limit cycle.
// Latency: expire_o is combinational, asserted on ACCESS cycle TIMEOUT_CYCLES.
// Backpressure: none; the arbiter decides what an expiry means.
module apb_arb_timeout
    import apb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire_o = en_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_periph_arbiter.sv
// Shares one APB master port between s0 and s1, round-robin, one transfer in flight (optional watchdog: APB_ARB_TIMEOUT_EN).
// Latency: request psel in cycle 0 -> SETUP cycle 1 -> earliest pready cycle 2; one IDLE bubble between transfers.
// Backpressure: losing requester keeps psel pending; ACCESS holds until m_pready_i (or watchdog expiry).
module apb_periph_arbiter
    import apb_arb_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [APB_ADDR_WIDTH-1:0] s0_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0] s0_pwdata_i,
    input  logic                      s0_pwrite_i,
    input  logic                      s0_psel_i,
    input  logic                      s0_penable_i,
    output logic [APB_DATA_WIDTH-1:0] s0_prdata_o,
    output logic                      s0_pready_o,
    output logic                      s0_pslverr_o,
    input  logic [APB_ADDR_WIDTH-1:0] s1_paddr_i,
    input  logic [APB_DATA_WIDTH-1:0] s1_pwdata_i,
    input  logic                      s1_pwrite_i,
    input  logic                      s1_psel_i,
    input  logic                      s1_penable_i,
    output logic [APB_DATA_WIDTH-1:0] s1_prdata_o,
    output logic                      s1_pready_o,
    output logic                      s1_pslverr_o,
    output logic [APB_ADDR_WIDTH-1:0] m_paddr_o,
    output logic [APB_DATA_WIDTH-1:0] m_pwdata_o,
    output logic                      m_pwrite_o,
    output logic                      m_psel_o,
    output logic                      m_penable_o,
    input  logic [APB_DATA_WIDTH-1:0] m_prdata_i,
    input  logic                      m_pready_i,
    input  logic                      m_pslverr_i,
    output logic                      grant_o,
    output logic                      busy_o
);

    arb_state_t                state_q, state_d;
    logic                      grant_q, grant_d;
    logic                      last_grant_q, last_grant_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;

    logic                      winner;
    logic                      expire;
    logic                      xfer_done;
    logic                      owner_psel;
    logic                      rsp_vld;
    logic [APB_DATA_WIDTH-1:0] rsp_dat;
    logic                      rsp_err;
    logic                      unused_penable;

    // Requester-side penable carries no information the arbiter needs.
    assign unused_penable = s0_penable_i ^ s1_penable_i;

`ifdef APB_ARB_TIMEOUT_EN
    apb_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (state_q == ARB_SETUP),
        .en_i     (state_q == ARB_ACCESS),
        .expire_o (expire)
    );
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    assign winner    = pick_winner(s0_psel_i, s1_psel_i, last_grant_q);
    assign xfer_done = (state_q == ARB_ACCESS) && (m_pready_i || expire);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pwrite_d     = pwrite_q;
        case (state_q)
            ARB_IDLE: begin
                if (s0_psel_i || s1_psel_i) begin
                    grant_d  = winner;
                    paddr_d  = winner ? s1_paddr_i  : s0_paddr_i;
                    pwdata_d = winner ? s1_pwdata_i : s0_pwdata_i;
                    pwrite_d = winner ? s1_pwrite_i : s0_pwrite_i;
                    state_d  = ARB_SETUP;
                end
            end
            ARB_SETUP: begin
                state_d = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                if (xfer_done) begin
                    last_grant_d = grant_q;
                    state_d      = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ARB_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pwrite_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pwrite_q     <= pwrite_d;
        end
    end

    assign m_psel_o    = (state_q == ARB_SETUP) || (state_q == ARB_ACCESS);
    assign m_penable_o = (state_q == ARB_ACCESS);
    assign m_paddr_o   = paddr_q;
    assign m_pwdata_o  = pwdata_q;
    assign m_pwrite_o  = pwrite_q;
    assign busy_o      = m_psel_o;
    assign grant_o     = grant_q;

    // An owner that dropped psel mid-transfer gets no response; the bus cycle still finishes.
    assign owner_psel = grant_q ? s1_psel_i : s0_psel_i;
    assign rsp_vld    = xfer_done && owner_psel;
    assign rsp_dat    = m_pready_i ? m_prdata_i : '0;
    assign rsp_err    = m_pready_i ? m_pslverr_i : 1'b1;

    assign s0_pready_o  = rsp_vld && !grant_q;
    assign s0_prdata_o  = s0_pready_o ? rsp_dat : '0;
    assign s0_pslverr_o = s0_pready_o && rsp_err;
    assign s1_pready_o  = rsp_vld && grant_q;
    assign s1_prdata_o  = s1_pready_o ? rsp_dat : '0;
    assign s1_pslverr_o = s1_pready_o && rsp_err;

endmodule
